red_pitaya_sort_pulser: RTL and testbench
=========================================

// Module: red_pitaya_sort_pulser
// PURPOSE
//  Receiving end of the FADS sort trigger: turns each rising edge of sort_trig into one timed actuation pulse.
//  The pulse is delayed, sized and followed by a dead time.
//  pulse_o drives the ASG external trigger, which gates the HV amplifier waveform.
//  Slave on the system bus; counts fired and dropped sort requests.
// PARAMETERS
//  TW  = 24 : width of delay/width/holdoff timers in adc_clk cycles (max ~134 ms @125 MHz)
//  CNW = 32 : width of fired/dropped event counters
// PORTS
//  adc_clk_i    in   1    ADC clock; the only clock
//  adc_rstn_i   in   1    asynchronous, active-low reset
//  sort_trig_i  in   1    sort request level from FADS detector (synchronous to adc_clk_i)
//  pulse_o      out  1    actuation pulse to ASG trigger
//  busy_o       out  1    high whenever state != IDLE
//  sys_addr     in   32   bus address (decode [19:0])
//  sys_wdata    in   32   bus write data
//  sys_sel      in   4    byte select (ignored; full-word writes)
//  sys_wen      in   1    bus write enable
//  sys_ren      in   1    bus read enable
//  sys_rdata    out  32   bus read data
//  sys_err      out  1    bus error, always 0
//  sys_ack      out  1    bus acknowledge
// BEHAVIOUR
//  Reset values: pulse_o=0, busy_o=0, sys_ack=0, sys_err=0, sys_rdata=0, state=IDLE, counters=0.
//  Reset values (regs): delay=0, width=1250, holdoff=12500, enable=0.
//  Edge detect: trig_q <= sort_trig_i; req = sort_trig_i & ~trig_q | soft_trig. A level held high yields one request.
//  FSM: IDLE -> DELAY -> FIRE -> HOLDOFF -> IDLE.
//   IDLE: req & enable -> latch shadow delay/width/holdoff, go DELAY (or FIRE if delay==0). req & !enable -> ignored, not counted.
//   DELAY: down-count delay cycles, then FIRE.
//   FIRE: pulse_o high for exactly max(width,1) cycles; fired_cnt++ on FIRE entry.
//   HOLDOFF: pulse_o low for holdoff cycles (0 = skip), then IDLE.
//  Latency: req at cycle N -> pulse_o rises at N+1+delay, falls at N+1+delay+max(width,1).
//  req while state != IDLE: dropped_cnt++; no re-trigger, no pulse extension.
//  Register writes while busy affect only the next accepted request (shadow copies).
//  enable cleared mid-operation: state -> IDLE next cycle, pulse_o low next cycle; no count changes.
//  Counters saturate at 2^CNW-1. clear_cnt in the same cycle as an increment: clear wins (result 0).
//  Bus: sys_ack <= sys_wen|sys_ren, one cycle after request; sys_rdata registered together with ack.
//  Bus: unmapped address reads 0 and acks; writes there are ignored.
// CONFIGURATION
//  0x00 delay[TW-1:0]     RW
//  0x04 width[TW-1:0]     RW
//  0x08 holdoff[TW-1:0]   RW
//  0x0C ctrl RW: [0] enable (RW); [1] soft_trig (W, self-clearing 1-cycle pulse); [2] clear_cnt (W, self-clearing)
//  0x10 status RO: [1:0] state (IDLE=0, DELAY=1, FIRE=2, HOLDOFF=3), [2] pulse_o
//  0x14 fired_cnt RO
//  0x18 dropped_cnt RO
//  Optional SORT_PULSER_TSTAMP_EN:
//   defined: 32-bit free-running cycle counter (wraps); value latched on FIRE entry; readable at 0x1C; clear_cnt also zeroes the latch.
//   undefined: no timestamp logic; 0x1C reads 0.
// STRUCTURE
//  Package red_pitaya_sort_pkg: state enum sort_state_t, register address localparams, reset-default localparams.
//  Sub-module red_pitaya_sort_timer: loadable TW-bit down-counter with load/en inputs and a done flag.
//   One instance, reused for the DELAY, FIRE and HOLDOFF phases.
// TESTING
//  1. enable=1, delay=10, width=5, holdoff=20; sort_trig_i 0->1 at cycle N (held 50 cycles)
//     -> pulse_o high cycles N+11..N+15 only; fired_cnt=1; dropped_cnt=0.
//  2. Same config; second rising edge 8 cycles after the first
//     -> no second pulse; dropped_cnt=1; edge at N+40 (IDLE again) -> fires, fired_cnt=2.
//  3. delay=0, width=0, holdoff=0; soft_trig write
//     -> pulse_o high exactly 1 cycle, starting 2 cycles after the write cycle; state back to IDLE the following cycle.
//  4. Clear enable during FIRE -> pulse_o low next cycle, status.state=IDLE.
//     Assert adc_rstn_i mid-DELAY -> all outputs 0 immediately (async).
//  5. Write width=100 during DELAY of a pulse with width=5 -> current pulse is 5 cycles; next pulse is 100 cycles.
//  6. Preload fired_cnt to saturation via force; trigger -> stays 0xFFFFFFFF.
//     clear_cnt in the same cycle as a FIRE entry -> fired_cnt=0.

Source files
------------

// File: rtl/red_pitaya_sort_pkg.sv
// ---------------------------------------------------------------------------
// red_pitaya_sort_pkg
//   Shared definitions for the sort pulser: FSM state encoding, bus register
//   map (20-bit decoded offsets) and reset defaults of the timing registers.
//   No ports (package).
// ---------------------------------------------------------------------------
package red_pitaya_sort_pkg;

  // Encoding is visible to software through the status register.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DELAY   = 2'd1,
    ST_FIRE    = 2'd2,
    ST_HOLDOFF = 2'd3
  } sort_state_t;

  // Register map
  localparam logic [19:0] ADDR_DELAY   = 20'h0_0000;
  localparam logic [19:0] ADDR_WIDTH   = 20'h0_0004;
  localparam logic [19:0] ADDR_HOLDOFF = 20'h0_0008;
  localparam logic [19:0] ADDR_CTRL    = 20'h0_000C;
  localparam logic [19:0] ADDR_STATUS  = 20'h0_0010;
  localparam logic [19:0] ADDR_FIRED   = 20'h0_0014;
  localparam logic [19:0] ADDR_DROPPED = 20'h0_0018;
  localparam logic [19:0] ADDR_TSTAMP  = 20'h0_001C;

  // Reset defaults in adc_clk cycles (10 us pulse, 100 us dead time @125 MHz)
  localparam logic [31:0] RST_DELAY   = 32'd0;
  localparam logic [31:0] RST_WIDTH   = 32'd1250;
  localparam logic [31:0] RST_HOLDOFF = 32'd12500;

endpackage

// File: rtl/red_pitaya_sort_timer.sv
// ---------------------------------------------------------------------------
// red_pitaya_sort_timer
//   Loadable TW-bit down-counter shared by the DELAY, FIRE and HOLDOFF
//   phases. Loading N makes o_done rise after N enabled cycles, so a phase
//   lasting L cycles is loaded with L-1.
// Ports
//   i_clk      clock
//   i_rstn     asynchronous active-low reset
//   i_load     load i_load_val (has priority over counting)
//   i_load_val value to load
//   i_en       count down while enabled (stops at zero)
//   o_done     counter is zero
// ---------------------------------------------------------------------------
module red_pitaya_sort_timer #(
  parameter int TW = 24
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_load,
  input  logic [TW-1:0] i_load_val,
  input  logic          i_en,
  output logic          o_done
);

  logic [TW-1:0] r_cnt;

  // Down-counter with load priority, saturating at zero
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_cnt <= {TW{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != {TW{1'b0}})) begin
      r_cnt <= r_cnt - TW'(1'b1);
    end
  end

  assign o_done = (r_cnt == {TW{1'b0}});

endmodule

// File: rtl/red_pitaya_sort_pulser.sv
// ---------------------------------------------------------------------------
// red_pitaya_sort_pulser
//   Turns each rising edge of sort_trig_i (or a software trigger) into one
//   actuation pulse: optional delay, pulse of max(width,1) cycles, then a
//   dead time. Requests arriving while busy are counted as dropped.
//   Build option: define SORT_PULSER_TSTAMP_EN to add a free-running cycle
//   counter latched on each pulse start (readable at 0x1C).
// Ports
//   adc_clk_i   ADC clock (only clock)
//   adc_rstn_i  asynchronous active-low reset
//   sort_trig_i sort request level, synchronous to adc_clk_i
//   pulse_o     actuation pulse to the ASG trigger
//   busy_o      high whenever the FSM is not idle
//   sys_*       system bus slave (addr/wdata/sel/wen/ren in, rdata/err/ack out)
// ---------------------------------------------------------------------------
module red_pitaya_sort_pulser
  import red_pitaya_sort_pkg::*;
#(
  parameter int TW  = 24,
  parameter int CNW = 32
) (
  input  logic        adc_clk_i,
  input  logic        adc_rstn_i,
  input  logic        sort_trig_i,
  output logic        pulse_o,
  output logic        busy_o,
  input  logic [31:0] sys_addr,
  input  logic [31:0] sys_wdata,
  input  logic [3:0]  sys_sel,
  input  logic        sys_wen,
  input  logic        sys_ren,
  output logic [31:0] sys_rdata,
  output logic        sys_err,
  output logic        sys_ack
);

  // phase length L -> timer load value L-1, with L clamped to at least 1
  function automatic logic [TW-1:0] f_len_m1(input logic [TW-1:0] v);
    if (v == {TW{1'b0}}) begin
      return {TW{1'b0}};
    end else begin
      return v - TW'(1'b1);
    end
  endfunction

  // ---------------- configuration registers ----------------
  logic [19:0]   w_addr;
  logic          w_wr_ctrl;
  logic [TW-1:0] r_delay;
  logic [TW-1:0] r_width;
  logic [TW-1:0] r_holdoff;
  logic          r_enable;
  logic          r_soft_trig;
  logic          r_clr_cnt;

  assign w_addr    = sys_addr[19:0];
  assign w_wr_ctrl = sys_wen & (w_addr == ADDR_CTRL);

  // Bus writes to config registers; soft_trig/clear_cnt are one-cycle pulses
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      r_delay     <= RST_DELAY[TW-1:0];
      r_width     <= RST_WIDTH[TW-1:0];
      r_holdoff   <= RST_HOLDOFF[TW-1:0];
      r_enable    <= 1'b0;
      r_soft_trig <= 1'b0;
      r_clr_cnt   <= 1'b0;
    end else begin
      r_soft_trig <= w_wr_ctrl & sys_wdata[1];
      r_clr_cnt   <= w_wr_ctrl & sys_wdata[2];
      if (sys_wen) begin
        case (w_addr)
          ADDR_DELAY:   r_delay   <= sys_wdata[TW-1:0];
          ADDR_WIDTH:   r_width   <= sys_wdata[TW-1:0];
          ADDR_HOLDOFF: r_holdoff <= sys_wdata[TW-1:0];
          ADDR_CTRL:    r_enable  <= sys_wdata[0];
          default:      ;
        endcase
      end
    end
  end

  // ---------------- request detection ----------------
  logic r_trig_q;
  logic w_req;
  logic w_enable_nxt;

  // Previous trigger level for rising-edge detection
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      r_trig_q <= 1'b0;
    end else begin
      r_trig_q <= sort_trig_i;
    end
  end

  assign w_req = (sort_trig_i & ~r_trig_q) | r_soft_trig;
  // Looking at the enable value being written lets a disable abort the
  // pulse on the very next cycle instead of one cycle later.
  assign w_enable_nxt = w_wr_ctrl ? sys_wdata[0] : r_enable;

  // ---------------- FSM ----------------
  sort_state_t   r_state;
  sort_state_t   w_state_nxt;
  logic          r_pulse;
  logic          r_busy;
  logic [TW-1:0] r_sh_width;
  logic [TW-1:0] r_sh_holdoff;
  logic          w_shadow_load;
  logic          w_tmr_load;
  logic [TW-1:0] w_tmr_val;
  logic          w_tmr_en;
  logic          w_tmr_done;
  logic          w_fire_entry;
  logic          w_drop;

  // Next-state, timer load and shadow capture decisions
  always_comb begin
    w_state_nxt   = r_state;
    w_tmr_load    = 1'b0;
    w_tmr_val     = {TW{1'b0}};
    w_shadow_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req && r_enable) begin
          w_shadow_load = 1'b1;
          w_tmr_load    = 1'b1;
          // delay goes straight into the timer, so it needs no shadow copy
          if (r_delay == {TW{1'b0}}) begin
            w_state_nxt = ST_FIRE;
            w_tmr_val   = f_len_m1(r_width);
          end else begin
            w_state_nxt = ST_DELAY;
            w_tmr_val   = f_len_m1(r_delay);
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DELAY: begin
        if (w_tmr_done) begin
          w_state_nxt = ST_FIRE;
          w_tmr_load  = 1'b1;
          w_tmr_val   = f_len_m1(r_sh_width);
        end else begin
          w_state_nxt = ST_DELAY;
        end
      end
      ST_FIRE: begin
        if (w_tmr_done) begin
          if (r_sh_holdoff == {TW{1'b0}}) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_HOLDOFF;
            w_tmr_load  = 1'b1;
            w_tmr_val   = f_len_m1(r_sh_holdoff);
          end
        end else begin
          w_state_nxt = ST_FIRE;
        end
      end
      ST_HOLDOFF: begin
        if (w_tmr_done) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_HOLDOFF;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    // disabling overrides everything, including a same-cycle accept
    if (!w_enable_nxt) begin
      w_state_nxt = ST_IDLE;
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  assign w_tmr_en     = (r_state != ST_IDLE);
  assign w_fire_entry = (w_state_nxt == ST_FIRE) && (r_state != ST_FIRE);
  assign w_drop       = w_req && (r_state != ST_IDLE) && w_enable_nxt;

  // State register; pulse/busy registered from next state so they align with it
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      r_state <= ST_IDLE;
      r_pulse <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pulse <= (w_state_nxt == ST_FIRE);
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  // Shadow copies so register writes while busy only affect the next request
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      r_sh_width   <= RST_WIDTH[TW-1:0];
      r_sh_holdoff <= RST_HOLDOFF[TW-1:0];
    end else if (w_shadow_load) begin
      r_sh_width   <= r_width;
      r_sh_holdoff <= r_holdoff;
    end
  end

  red_pitaya_sort_timer #(
    .TW (TW)
  ) u_timer (
    .i_clk      (adc_clk_i),
    .i_rstn     (adc_rstn_i),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_en       (w_tmr_en),
    .o_done     (w_tmr_done)
  );

  // ---------------- event counters ----------------
  logic [CNW-1:0] r_fired_cnt;
  logic [CNW-1:0] r_dropped_cnt;

  // Saturating fired/dropped counters; clear wins over a same-cycle increment
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      r_fired_cnt   <= {CNW{1'b0}};
      r_dropped_cnt <= {CNW{1'b0}};
    end else if (r_clr_cnt) begin
      r_fired_cnt   <= {CNW{1'b0}};
      r_dropped_cnt <= {CNW{1'b0}};
    end else begin
      if (w_fire_entry && (r_fired_cnt != {CNW{1'b1}})) begin
        r_fired_cnt <= r_fired_cnt + CNW'(1'b1);
      end
      if (w_drop && (r_dropped_cnt != {CNW{1'b1}})) begin
        r_dropped_cnt <= r_dropped_cnt + CNW'(1'b1);
      end
    end
  end

`ifdef SORT_PULSER_TSTAMP_EN
  logic [31:0] r_tstamp_cnt;
  logic [31:0] r_tstamp;

  // Free-running cycle counter and its snapshot at each pulse start
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      r_tstamp_cnt <= 32'd0;
      r_tstamp     <= 32'd0;
    end else begin
      r_tstamp_cnt <= r_tstamp_cnt + 32'd1;
      if (r_clr_cnt) begin
        r_tstamp <= 32'd0;
      end else if (w_fire_entry) begin
        r_tstamp <= r_tstamp_cnt;
      end
    end
  end
`endif

  // ---------------- bus read side ----------------
  logic [31:0] w_rdata;
  logic [31:0] r_rdata;
  logic        r_ack;
  logic        w_unused_bits;

  // Read mux; unmapped offsets read zero
  always_comb begin
    w_rdata = 32'd0;
    case (w_addr)
      ADDR_DELAY:   w_rdata = 32'(r_delay);
      ADDR_WIDTH:   w_rdata = 32'(r_width);
      ADDR_HOLDOFF: w_rdata = 32'(r_holdoff);
      ADDR_CTRL:    w_rdata = {31'd0, r_enable};
      ADDR_STATUS:  w_rdata = {29'd0, r_pulse, r_state};
      ADDR_FIRED:   w_rdata = 32'(r_fired_cnt);
      ADDR_DROPPED: w_rdata = 32'(r_dropped_cnt);
`ifdef SORT_PULSER_TSTAMP_EN
      ADDR_TSTAMP:  w_rdata = r_tstamp;
`endif
      default:      w_rdata = 32'd0;
    endcase
  end

  // Ack one cycle after any access, read data registered alongside
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      r_ack   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_ack   <= sys_wen | sys_ren;
      r_rdata <= sys_ren ? w_rdata : 32'd0;
    end
  end

  // byte selects and upper address bits are intentionally not decoded
  assign w_unused_bits = ^{sys_sel, sys_addr[31:20], sys_wdata};

  assign pulse_o   = r_pulse;
  assign busy_o    = r_busy;
  assign sys_rdata = r_rdata;
  assign sys_ack   = r_ack;
  assign sys_err   = 1'b0;

endmodule

// File: tb/tb_red_pitaya_sort_pulser.sv
// ---------------------------------------------------------------------------
// tb_red_pitaya_sort_pulser
//   Directed bench for red_pitaya_sort_pulser. Inputs change 1 time unit
//   after the rising clock edge; outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_red_pitaya_sort_pulser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sort_trig;
  logic        pulse;
  logic        busy;
  logic [31:0] sys_addr;
  logic [31:0] sys_wdata;
  logic [3:0]  sys_sel;
  logic        sys_wen;
  logic        sys_ren;
  logic [31:0] sys_rdata;
  logic        sys_err;
  logic        sys_ack;

  int n_vec = 0;
  int n_err = 0;

  always #4 clk = ~clk;

  red_pitaya_sort_pulser dut (
    .adc_clk_i   (clk),
    .adc_rstn_i  (rst_n),
    .sort_trig_i (sort_trig),
    .pulse_o     (pulse),
    .busy_o      (busy),
    .sys_addr    (sys_addr),
    .sys_wdata   (sys_wdata),
    .sys_sel     (sys_sel),
    .sys_wen     (sys_wen),
    .sys_ren     (sys_ren),
    .sys_rdata   (sys_rdata),
    .sys_err     (sys_err),
    .sys_ack     (sys_ack)
  );

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
    sys_addr  = addr;
    sys_wdata = data;
    sys_wen   = 1'b1;
    step(1);
    sys_wen   = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] addr, output logic [31:0] data, output logic ack);
    sys_addr = addr;
    sys_ren  = 1'b1;
    step(1);
    sys_ren  = 1'b0;
    data     = sys_rdata;
    ack      = sys_ack;
  endtask

  // Drive sort_trig high in the windows [s,e) and record pulse activity
  task automatic observe(input int ncyc, input int s0, input int e0, input int s1,
                         input int e1, input int s2, input int e2,
                         output int first, output int last, output int cnt);
    first = -1;
    last  = -1;
    cnt   = 0;
    for (int k = 0; k < ncyc; k++) begin
      sort_trig = (k >= s0 && k < e0) || (k >= s1 && k < e1) || (k >= s2 && k < e2);
      if (pulse) begin
        if (first < 0) first = k;
        last = k;
        cnt++;
      end
      step(1);
    end
    sort_trig = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        ack;
    int          f, l, c;

    rst_n = 1'b0; sort_trig = 1'b0; sys_addr = 32'd0; sys_wdata = 32'd0;
    sys_sel = 4'hF; sys_wen = 1'b0; sys_ren = 1'b0;
    #2;
    chk_eq("rst_pulse", {31'd0, pulse}, 32'd0);
    chk_eq("rst_busy",  {31'd0, busy},  32'd0);
    chk_eq("rst_ack",   {31'd0, sys_ack}, 32'd0);
    chk_eq("rst_err",   {31'd0, sys_err}, 32'd0);
    chk_eq("rst_rdata", sys_rdata, 32'd0);
    step(3);
    rst_n = 1'b1;
    step(2);

    // reset register values and bus decode
    bus_rd(32'h00, rd, ack); chk_eq("def_delay", rd, 32'd0); chk_eq("rd_ack", {31'd0, ack}, 32'd1);
    bus_rd(32'h04, rd, ack); chk_eq("def_width", rd, 32'd1250);
    bus_rd(32'h08, rd, ack); chk_eq("def_holdoff", rd, 32'd12500);
    bus_rd(32'h0C, rd, ack); chk_eq("def_ctrl", rd, 32'd0);
    bus_rd(32'h10, rd, ack); chk_eq("def_status", rd, 32'd0);
    bus_rd(32'h14, rd, ack); chk_eq("def_fired", rd, 32'd0);
    bus_wr(32'h40, 32'hFFFF_FFFF);
    bus_rd(32'h40, rd, ack); chk_eq("unmapped_rd", rd, 32'd0); chk_eq("unmapped_ack", {31'd0, ack}, 32'd1);
    bus_rd(32'h0010_0004, rd, ack); chk_eq("alias_width", rd, 32'd1250);
`ifndef SORT_PULSER_TSTAMP_EN
    bus_rd(32'h1C, rd, ack); chk_eq("tstamp_absent", rd, 32'd0);
`endif

    // trigger while disabled is ignored and not counted
    observe(20, 0, 5, -1, -1, -1, -1, f, l, c);
    chk_eq("dis_no_pulse", c, 32'd0);
    bus_rd(32'h18, rd, ack); chk_eq("dis_no_drop", rd, 32'd0);

    // 1: single pulse from a held level
    bus_wr(32'h00, 32'd10); bus_wr(32'h04, 32'd5); bus_wr(32'h08, 32'd20); bus_wr(32'h0C, 32'd1);
    observe(60, 0, 50, -1, -1, -1, -1, f, l, c);
    chk_eq("t1_first", f, 32'd11); chk_eq("t1_last", l, 32'd15); chk_eq("t1_cnt", c, 32'd5);
    bus_rd(32'h14, rd, ack); chk_eq("t1_fired", rd, 32'd1);
    bus_rd(32'h18, rd, ack); chk_eq("t1_dropped", rd, 32'd0);

    // 2: edge during DELAY dropped, later edge fires (counters cleared first)
    bus_wr(32'h0C, 32'd5);
    observe(70, 0, 4, 8, 30, 40, 45, f, l, c);
    chk_eq("t2_first", f, 32'd11); chk_eq("t2_last", l, 32'd55); chk_eq("t2_cnt", c, 32'd10);
    bus_rd(32'h14, rd, ack); chk_eq("t2_fired", rd, 32'd2);
    bus_rd(32'h18, rd, ack); chk_eq("t2_dropped", rd, 32'd1);

    // 3: zero delay/width/holdoff via soft trigger
    bus_wr(32'h00, 32'd0); bus_wr(32'h04, 32'd0); bus_wr(32'h08, 32'd0);
    bus_wr(32'h0C, 32'd3);
    chk_eq("t3_w1_pulse", {31'd0, pulse}, 32'd0);
    step(1);
    chk_eq("t3_w2_pulse", {31'd0, pulse}, 32'd1); chk_eq("t3_w2_busy", {31'd0, busy}, 32'd1);
    step(1);
    chk_eq("t3_w3_pulse", {31'd0, pulse}, 32'd0); chk_eq("t3_w3_busy", {31'd0, busy}, 32'd0);
    bus_rd(32'h10, rd, ack); chk_eq("t3_status", rd, 32'd0);

    // 4a: disable during FIRE
    bus_wr(32'h04, 32'd100);
    bus_wr(32'h0C, 32'd3);
    step(4);
    chk_eq("t4_in_fire", {31'd0, pulse}, 32'd1);
    bus_wr(32'h0C, 32'd0);
    chk_eq("t4_abort_pulse", {31'd0, pulse}, 32'd0); chk_eq("t4_abort_busy", {31'd0, busy}, 32'd0);
    bus_rd(32'h10, rd, ack); chk_eq("t4_status", rd, 32'd0);
    bus_rd(32'h14, rd, ack); chk_eq("t4_fired", rd, 32'd4);
    bus_rd(32'h18, rd, ack); chk_eq("t4_dropped", rd, 32'd1);

    // 4b: asynchronous reset in the middle of DELAY
    bus_wr(32'h00, 32'd50); bus_wr(32'h04, 32'd5); bus_wr(32'h08, 32'd0);
    bus_wr(32'h0C, 32'd3);
    step(5);
    chk_eq("t4b_busy", {31'd0, busy}, 32'd1);
    sys_addr = 32'h10; sys_ren = 1'b1;
    step(1);
    sys_ren = 1'b0;
    chk_eq("t4b_pre_ack", {31'd0, sys_ack}, 32'd1); chk_eq("t4b_pre_status", sys_rdata, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("t4b_rst_busy", {31'd0, busy}, 32'd0); chk_eq("t4b_rst_pulse", {31'd0, pulse}, 32'd0);
    chk_eq("t4b_rst_ack", {31'd0, sys_ack}, 32'd0); chk_eq("t4b_rst_rdata", sys_rdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(2);
    bus_rd(32'h14, rd, ack); chk_eq("t4b_fired_rst", rd, 32'd0);

    // 5: width written during DELAY applies only to the next pulse
    bus_wr(32'h00, 32'd10); bus_wr(32'h04, 32'd5); bus_wr(32'h08, 32'd5);
    bus_wr(32'h0C, 32'd3);
    step(2);
    bus_wr(32'h04, 32'd100);
    observe(30, -1, -1, -1, -1, -1, -1, f, l, c);
    chk_eq("t5a_first", f, 32'd8); chk_eq("t5a_cnt", c, 32'd5);
    bus_wr(32'h0C, 32'd3);
    observe(120, -1, -1, -1, -1, -1, -1, f, l, c);
    chk_eq("t5b_first", f, 32'd11); chk_eq("t5b_last", l, 32'd110); chk_eq("t5b_cnt", c, 32'd100);
    bus_rd(32'h14, rd, ack); chk_eq("t5_fired", rd, 32'd2);

    // 6: saturation and clear-wins
    force dut.r_fired_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_fired_cnt;
    bus_wr(32'h00, 32'd0); bus_wr(32'h04, 32'd0); bus_wr(32'h08, 32'd0);
    bus_wr(32'h0C, 32'd3);
    step(4);
    bus_rd(32'h14, rd, ack); chk_eq("t6_saturate", rd, 32'hFFFF_FFFF);
    bus_wr(32'h0C, 32'd7);
    step(1);
    chk_eq("t6_clr_pulse", {31'd0, pulse}, 32'd1);
    step(2);
    bus_rd(32'h14, rd, ack); chk_eq("t6_clr_wins", rd, 32'd0);
    bus_wr(32'h0C, 32'd3);
    step(4);
    bus_rd(32'h14, rd, ack); chk_eq("t6_after_clr", rd, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
